// File: rtl/ps2_kbd_fifo_if.sv
// Keyboard byte strobe and CPU register bus bundle for ps2_kbd_fifo.
interface ps2_kbd_fifo_if;
  logic [7:0]  ps2_kbd_code_i;
  logic        ps2_kbd_strobe_i;
  logic        ps2_kbd_err_i;
  logic        sel_i;
  logic        wr_i;
  logic        addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        irq_o;

  modport slave (
    input  ps2_kbd_code_i, ps2_kbd_strobe_i, ps2_kbd_err_i,
    input  sel_i, wr_i, addr_i, wdata_i,
    output rdata_o, irq_o
  );

  modport master (
    output ps2_kbd_code_i, ps2_kbd_strobe_i, ps2_kbd_err_i,
    output sel_i, wr_i, addr_i, wdata_i,
    input  rdata_o, irq_o
  );
endinterface

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard input stage: folds E0/F0 prefixes into 10-bit key events,
// queues them in a FIFO and exposes DATA/STATUS registers with a level irq.
module ps2_kbd_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input logic           clk,
  input logic           reset_i,
  ps2_kbd_fifo_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned EV_W  = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               irq_q, irq_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [EV_W-1:0]    mem_q [DEPTH];

  logic               push_c, pop_c;
  logic [EV_W-1:0]    event_c;
  logic               full_c, nonempty_c;
  logic               rd_data_c, rd_stat_c, wr_stat_c;
  logic               good_byte_c, err_byte_c, term_byte_c;
  logic               ext_c, brk_c;
  logic               unused_wdata_c;

  assign unused_wdata_c = ^{bus.wdata_i[31:4], bus.wdata_i[1:0]};

  // Decoder, FIFO bookkeeping and register access.
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    push_c   = 1'b0;
    pop_c    = 1'b0;

    full_c      = (count_q == CNT_W'(DEPTH));
    nonempty_c  = (count_q != '0);
    rd_data_c   = bus.sel_i & ~bus.wr_i & ~bus.addr_i;
    rd_stat_c   = bus.sel_i & ~bus.wr_i &  bus.addr_i;
    wr_stat_c   = bus.sel_i &  bus.wr_i &  bus.addr_i;
    good_byte_c = bus.ps2_kbd_strobe_i & ~bus.ps2_kbd_err_i;
    err_byte_c  = bus.ps2_kbd_strobe_i &  bus.ps2_kbd_err_i;
    term_byte_c = good_byte_c & (bus.ps2_kbd_code_i != 8'hE0)
                              & (bus.ps2_kbd_code_i != 8'hF0);
    ext_c       = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    brk_c       = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    event_c     = {ext_c, brk_c, bus.ps2_kbd_code_i};

    if (err_byte_c) begin
      state_d = S_IDLE;
    end else if (good_byte_c) begin
      case (bus.ps2_kbd_code_i)
        8'hE0: state_d = brk_c ? S_EXT_BRK : S_EXT;
        8'hF0: state_d = ext_c ? S_EXT_BRK : S_BRK;
        default: state_d = S_IDLE;
      endcase
    end

    if (rd_data_c) begin
      if (nonempty_c) begin
        pop_c   = 1'b1;
        rdata_d = {21'b0, 1'b1, mem_q[rptr_q]};
      end else begin
        rdata_d = 32'h0;
      end
    end else if (rd_stat_c) begin
      rdata_d = {16'b0, 8'(count_q), 4'b0, err_q, ovf_q, full_c, nonempty_c};
    end

    // A pop in the same cycle frees the slot for a push into a full FIFO.
    if (term_byte_c) begin
      if (!full_c || pop_c) begin
        push_c = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (wr_stat_c && bus.wdata_i[2] && !(term_byte_c && !push_c)) begin
      ovf_d = 1'b0;
    end
    if (wr_stat_c && bus.wdata_i[3]) begin
      err_d = 1'b0;
    end
    if (err_byte_c) begin
      err_d = 1'b1;
    end

    if (push_c) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    irq_d   = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset_i && push_c) begin
      mem_q[wptr_q] <= event_c;
    end
  end

  assign bus.rdata_o = rdata_q;
  assign bus.irq_o   = irq_q;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Bench for ps2_kbd_fifo: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_ps2_kbd_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  ps2_kbd_fifo_if bus ();

  ps2_kbd_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: event queue plus pending prefix flags.
  bit [9:0]  m_q[$];
  bit        m_ext, m_brk, m_ovf, m_err;
  bit [31:0] m_rd;

  task automatic model_step(input bit rst, input bit stb, input bit er,
                            input bit [7:0] code, input bit sel, input bit wr,
                            input bit addr, input bit [31:0] wdata);
    int n;
    if (rst) begin
      m_q.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0; m_rd = 0;
      return;
    end
    n = m_q.size();
    if (sel && !wr) begin
      if (addr)
        m_rd = n * 256 + (m_err ? 8 : 0) + (m_ovf ? 4 : 0)
             + ((n == DEPTH) ? 2 : 0) + ((n > 0) ? 1 : 0);
      else if (n > 0)
        m_rd = 32'h400 + 32'(m_q.pop_front());
      else
        m_rd = 0;
    end
    if (sel && wr && addr) begin
      if (wdata[2]) m_ovf = 0;
      if (wdata[3]) m_err = 0;
    end
    if (stb) begin
      if (er) begin
        m_ext = 0; m_brk = 0; m_err = 1;
      end else if (code == 8'hE0) begin
        m_ext = 1;
      end else if (code == 8'hF0) begin
        m_brk = 1;
      end else begin
        if (m_q.size() < DEPTH)
          m_q.push_back(10'((m_ext ? 512 : 0) + (m_brk ? 256 : 0) + int'(code)));
        else
          m_ovf = 1;
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  task automatic check(input string name, input bit [31:0] act, input bit [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, advance model, clock, settle.
  task automatic cycle(input bit rst, input bit stb, input bit er, input bit [7:0] code,
                       input bit sel, input bit wr, input bit addr, input bit [31:0] wdata);
    reset_i              = rst;
    bus.ps2_kbd_strobe_i = stb;
    bus.ps2_kbd_err_i    = er;
    bus.ps2_kbd_code_i   = code;
    bus.sel_i            = sel;
    bus.wr_i             = wr;
    bus.addr_i           = addr;
    bus.wdata_i          = wdata;
    model_step(rst, stb, er, code, sel, wr, addr, wdata);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit [7:0] code);
    cycle(0, 1, 0, code, 0, 0, 0, 0);
  endtask
  task automatic rd_data();
    cycle(0, 0, 0, 8'h00, 1, 0, 0, 0);
  endtask
  task automatic rd_stat();
    cycle(0, 0, 0, 8'h00, 1, 0, 1, 0);
  endtask
  task automatic wr_stat(input bit [31:0] v);
    cycle(0, 0, 0, 8'h00, 1, 1, 1, v);
  endtask

  typedef struct {
    bit        stb;
    bit        er;
    bit [7:0]  code;
    bit        sel;
    bit        wr;
    bit        addr;
    bit [31:0] wdata;
    bit        chk_rd;
    bit [31:0] exp_rd;
    bit        exp_irq;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // stb er code sel wr addr wdata chk exp_rd exp_irq
    vecs.push_back('{1, 0, 8'h1C, 0, 0, 0, 0, 0, 32'h0,    1});
    vecs.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 1, 32'h41C,  0});
    vecs.push_back('{1, 0, 8'hE0, 0, 0, 0, 0, 0, 32'h0,    0});
    vecs.push_back('{1, 0, 8'hF0, 0, 0, 0, 0, 0, 32'h0,    0});
    vecs.push_back('{1, 0, 8'h75, 0, 0, 0, 0, 0, 32'h0,    1});
    vecs.push_back('{0, 0, 8'h00, 1, 0, 1, 0, 1, 32'h0101, 1});
    vecs.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 1, 32'h775,  0});
    vecs.push_back('{1, 0, 8'hF0, 0, 0, 0, 0, 0, 32'h0,    0});
    vecs.push_back('{1, 1, 8'h55, 0, 0, 0, 0, 0, 32'h0,    0});
    vecs.push_back('{1, 0, 8'h1C, 0, 0, 0, 0, 0, 32'h0,    1});
    vecs.push_back('{0, 0, 8'h00, 1, 0, 1, 0, 1, 32'h0109, 1});
    vecs.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 1, 32'h41C,  0});
    vecs.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 1, 32'h0,    0});
    vecs.push_back('{0, 0, 8'h00, 1, 1, 1, 8, 0, 32'h0,    0});
    vecs.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 0, 32'h0,    0});
    vecs.push_back('{0, 0, 8'h00, 1, 0, 1, 0, 1, 32'h0000, 0});

    cycle(1, 0, 0, 8'h00, 0, 0, 0, 0);
    check("reset_rdata", bus.rdata_o, 32'h0);
    check("reset_irq", 32'(bus.irq_o), 32'h0);

    foreach (vecs[i]) begin
      cycle(0, vecs[i].stb, vecs[i].er, vecs[i].code, vecs[i].sel,
            vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), bus.rdata_o, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), 32'(bus.irq_o), 32'(vecs[i].exp_irq));
    end

    // Overflow: 17 pushes into a 16-deep FIFO.
    for (int i = 1; i <= 17; i++) push(8'(i));
    rd_stat();
    check("ovf_status", bus.rdata_o, 32'h1007);
    for (int i = 1; i <= 16; i++) begin
      rd_data();
      check($sformatf("ovf_read%0d", i), bus.rdata_o, 32'h400 + 32'(i));
    end
    check("ovf_irq_empty", 32'(bus.irq_o), 32'h0);
    rd_data();
    check("ovf_read_empty", bus.rdata_o, 32'h0);
    wr_stat(32'h4);
    rd_stat();
    check("ovf_cleared", bus.rdata_o, 32'h0);

    // Push and pop in the same cycle on a full FIFO.
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    cycle(0, 1, 0, 8'h2A, 1, 0, 0, 0);
    check("full_pushpop_rd", bus.rdata_o, 32'h430);
    rd_stat();
    check("full_pushpop_stat", bus.rdata_o, 32'h1003);
    for (int i = 1; i < 16; i++) rd_data();
    check("full_pushpop_last_old", bus.rdata_o, 32'h43F);
    rd_data();
    check("full_pushpop_new", bus.rdata_o, 32'h42A);

    // Push and pop in the same cycle on an empty FIFO.
    cycle(0, 1, 0, 8'h33, 1, 0, 0, 0);
    check("empty_pushpop_rd", bus.rdata_o, 32'h0);
    check("empty_pushpop_irq", 32'(bus.irq_o), 32'h1);
    rd_data();
    check("empty_pushpop_data", bus.rdata_o, 32'h433);

    // Error strobe races a STATUS write clearing ERR: the set wins.
    cycle(0, 1, 1, 8'h12, 1, 1, 1, 32'h8);
    rd_stat();
    check("err_set_wins", bus.rdata_o, 32'h0008);
    wr_stat(32'h8);

    // Reset mid-operation drops prefix and queued events.
    push(8'hE0);
    push(8'h11); push(8'h12); push(8'h13);
    cycle(1, 0, 0, 8'h00, 0, 0, 0, 0);
    check("midreset_irq", 32'(bus.irq_o), 32'h0);
    push(8'h1C);
    rd_stat();
    check("midreset_stat", bus.rdata_o, 32'h0101);
    rd_data();
    check("midreset_data", bus.rdata_o, 32'h41C);

    // Randomized run against the reference model.
    cycle(1, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      bit rst, stb, er, sel, wr, addr;
      bit [7:0] code;
      bit [31:0] wdata;
      int rd_pct;
      rd_pct = ((c / 500) % 2 == 0) ? 10 : 70;
      rst = ($urandom_range(999) < 3);
      stb = ($urandom_range(99) < 60);
      er  = ($urandom_range(99) < 4);
      case ($urandom_range(5))
        0: code = 8'hE0;
        1: code = 8'hF0;
        2: code = 8'hE1;
        default: code = 8'($urandom);
      endcase
      sel   = ($urandom_range(99) < rd_pct);
      wr    = ($urandom_range(99) < 15);
      addr  = ($urandom_range(99) < 30);
      wdata = $urandom;
      cycle(rst, stb, er, code, sel, wr, addr, wdata);
      check($sformatf("rand%0d_rdata", c), bus.rdata_o, m_rd);
      check($sformatf("rand%0d_irq", c), 32'(bus.irq_o), 32'(m_q.size() != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
